// File: rtl/iob_config_loader_pkg.sv
// Shared types and defaults for the IOB configuration loader.
// The loader supports NUM_IOB >= 2 and WORD_W >= 2.
package iob_config_loader_pkg;

    localparam int          NUM_IOB_DEF   = 4;
    localparam int          WORD_W_DEF    = 8;
    localparam logic [7:0]  SYNC_WORD_DEF = 8'hA5;

    typedef enum logic [2:0] {
        HUNT,
        LOAD,
        CHECK,
        COMMIT,
        FAIL
    } cfg_state_t;

endpackage

// File: rtl/iob_config_loader_if.sv
// Serial configuration stream in, committed switch-enable words out.
interface iob_config_loader_if
    import iob_config_loader_pkg::*;
#(
    parameter int NUM_IOB = NUM_IOB_DEF,
    parameter int WORD_W  = WORD_W_DEF
);
    logic                        cfg_din;
    logic                        cfg_valid;
    logic                        cfg_clear;
    logic [NUM_IOB*WORD_W-1:0]   sram_con_bit;
    logic                        cfg_busy;
    logic                        cfg_done;
    logic                        cfg_error;

    modport master (
        output cfg_din, cfg_valid, cfg_clear,
        input  sram_con_bit, cfg_busy, cfg_done, cfg_error
    );

    modport slave (
        input  cfg_din, cfg_valid, cfg_clear,
        output sram_con_bit, cfg_busy, cfg_done, cfg_error
    );
endinterface

// File: rtl/iob_cfg_sync_hunt.sv
// Sliding 8-bit sync-pattern detector; match is a combinational pulse on the
// accepting edge so the FSM can leave HUNT on that same edge.
module iob_cfg_sync_hunt
    import iob_config_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic clr,
    input  logic din,
    output logic match
);

    logic [7:0] hunt_q;
    logic [7:0] hunt_d;
    logic [7:0] hunt_shift;

    assign hunt_shift = {hunt_q[6:0], din};
    assign match      = shift_en && !clr && (hunt_shift == SYNC_WORD);

    always_comb begin
        hunt_d = hunt_q;
        if (clr) begin
            hunt_d = '0;
        end else if (shift_en) begin
            hunt_d = hunt_shift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hunt_q <= '0;
        end else begin
            hunt_q <= hunt_d;
        end
    end

endmodule

// File: rtl/iob_config_loader.sv
// Frame loader: sync, NUM_IOB words, XOR checksum; commits all words to the
// IOB switch enables atomically, only on a matching checksum.
module iob_config_loader
    import iob_config_loader_pkg::*;
#(
    parameter int         NUM_IOB   = NUM_IOB_DEF,
    parameter int         WORD_W    = WORD_W_DEF,
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    iob_config_loader_if.slave   cfg_bus
);

    localparam int TOTAL_W = NUM_IOB * WORD_W;
    localparam int CNT_W   = $clog2(TOTAL_W);
    localparam int WBIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    cfg_state_t          state_q, state_d;
    logic [TOTAL_W-1:0]  shadow_q, shadow_d;
    logic [TOTAL_W-1:0]  sram_q, sram_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [WORD_W-1:0]   xor_q, xor_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WBIT_W-1:0]   wbit_q, wbit_d;

    logic [WORD_W-1:0]   word_shift;
    logic                word_last;
    logic                sync_match;
    logic                hunt_shift_en;
    logic                hunt_clr;

    assign word_shift    = {word_q[WORD_W-2:0], cfg_bus.cfg_din};
    assign word_last     = (wbit_q == WBIT_W'(WORD_W - 1));
    assign hunt_shift_en = cfg_bus.cfg_valid && (state_q == HUNT);
    assign hunt_clr      = cfg_bus.cfg_clear || (state_q != HUNT);

    iob_cfg_sync_hunt #(
        .SYNC_WORD (SYNC_WORD)
    ) u_sync_hunt (
        .clk      (clk),
        .rst      (rst),
        .shift_en (hunt_shift_en),
        .clr      (hunt_clr),
        .din      (cfg_bus.cfg_din),
        .match    (sync_match)
    );

    // Completed words enter the shadow from the top, so the first word ends up in IOB 0's slot.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        sram_d    = sram_q;
        word_d    = word_q;
        xor_d     = xor_q;
        bit_cnt_d = bit_cnt_q;
        wbit_d    = wbit_q;

        if (cfg_bus.cfg_clear) begin
            state_d   = HUNT;
            shadow_d  = '0;
            sram_d    = '0;
            word_d    = '0;
            xor_d     = '0;
            bit_cnt_d = '0;
            wbit_d    = '0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    if (sync_match) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    if (cfg_bus.cfg_valid) begin
                        word_d    = word_shift;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        wbit_d    = wbit_q + WBIT_W'(1);
                        if (word_last) begin
                            wbit_d   = '0;
                            shadow_d = {word_shift, shadow_q[TOTAL_W-1:WORD_W]};
                            xor_d    = xor_q ^ word_shift;
                        end
                        if (bit_cnt_q == CNT_W'(TOTAL_W - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (cfg_bus.cfg_valid) begin
                        word_d = word_shift;
                        wbit_d = wbit_q + WBIT_W'(1);
                        // Loading sram here makes the new config land together with done.
                        if (word_last) begin
                            wbit_d = '0;
                            if (word_shift == xor_q) begin
                                sram_d  = shadow_q;
                                state_d = COMMIT;
                            end else begin
                                state_d = FAIL;
                            end
                        end
                    end
                end
                COMMIT, FAIL: begin
                    state_d   = HUNT;
                    shadow_d  = '0;
                    word_d    = '0;
                    xor_d     = '0;
                    bit_cnt_d = '0;
                    wbit_d    = '0;
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HUNT;
            shadow_q  <= '0;
            sram_q    <= '0;
            word_q    <= '0;
            xor_q     <= '0;
            bit_cnt_q <= '0;
            wbit_q    <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            sram_q    <= sram_d;
            word_q    <= word_d;
            xor_q     <= xor_d;
            bit_cnt_q <= bit_cnt_d;
            wbit_q    <= wbit_d;
        end
    end

    assign cfg_bus.sram_con_bit = sram_q;
    assign cfg_bus.cfg_busy     = (state_q == LOAD) || (state_q == CHECK);
    assign cfg_bus.cfg_done     = (state_q == COMMIT);
    assign cfg_bus.cfg_error    = (state_q == FAIL);

endmodule

// File: tb/tb_iob_config_loader.sv
// Scoreboard bench for iob_config_loader with two IOBs: frames push their
// expected outcome, a monitor pops and compares on each done/error pulse.
module tb_iob_config_loader;

    localparam logic [7:0] SYNC = 8'hA5;

    typedef struct {
        bit          is_err;
        logic [15:0] sram;
        int          cyc;
        int          busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0;
    logic [15:0] model_sram = '0;
    exp_t exp_q[$];

    iob_config_loader_if #(.NUM_IOB(2), .WORD_W(8)) bus ();

    iob_config_loader #(
        .NUM_IOB   (2),
        .WORD_W    (8),
        .SYNC_WORD (8'hA5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: each done/error pulse is matched against the oldest expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            busy_run = 0;
        end else if (bus.cfg_busy) begin
            busy_run++;
        end else begin
            if (bus.cfg_done || bus.cfg_error) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_pulse", {30'd0, bus.cfg_done, bus.cfg_error}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("done",       {31'd0, bus.cfg_done},  {31'd0, !e.is_err});
                    checkOutput("error",      {31'd0, bus.cfg_error}, {31'd0, e.is_err});
                    checkOutput("sram",       {16'd0, bus.sram_con_bit}, {16'd0, e.sram});
                    checkOutput("pulse_cyc",  cyc, e.cyc);
                    checkOutput("busy_cycles", busy_run, e.busy);
                end
            end
            busy_run = 0;
        end
    end

    task automatic sendBit(input logic b);
        @(negedge clk);
        bus.cfg_din   = b;
        bus.cfg_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        bus.cfg_din   = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        for (int k = 0; k < 60 && exp_q.size() > 0; k++) @(negedge clk);
        checkOutput(tag, exp_q.size(), 32'd0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_sram = '0;
    endtask

    // Full frame: sync, w0 (IOB 0), w1 (IOB 1), checksum; optional 3-cycle stalls
    task automatic applyStimulus(input logic [7:0] w0, input logic [7:0] w1,
                                 input logic [7:0] chk, input int stall_every);
        logic [31:0] frame;
        int stalls;
        int busy_stalls;
        int start;
        exp_t e;
        frame = {SYNC, w0, w1, chk};
        stalls = 0;
        busy_stalls = 0;
        start = 0;
        for (int i = 0; i < 32; i++) begin
            if (stall_every > 0 && i > 0 && (i % stall_every) == 0) begin
                repeat (3) begin
                    @(negedge clk);
                    bus.cfg_valid = 1'b0;
                end
                stalls += 3;
                if (i >= 8) busy_stalls += 3;
            end
            sendBit(frame[31-i]);
            if (i == 0) start = cyc;
            if (i == 31) begin
                e.is_err = (chk != (w0 ^ w1));
                e.sram   = e.is_err ? model_sram : {w1, w0};
                e.cyc    = start + 32 + stalls;
                e.busy   = 24 + busy_stalls;
                model_sram = e.sram;
                exp_q.push_back(e);
            end
        end
        idle();
        waitDrain("frame_drain");
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [15:0] partial;
        bus.cfg_din   = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_clear = 1'b0;

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_sram",  {16'd0, bus.sram_con_bit}, 32'd0);
        checkOutput("reset_busy",  {31'd0, bus.cfg_busy},  32'd0);
        checkOutput("reset_done",  {31'd0, bus.cfg_done},  32'd0);
        checkOutput("reset_error", {31'd0, bus.cfg_error}, 32'd0);
        rst = 1'b0;

        $display("[TB] basic frame");
        applyStimulus(8'h81, 8'h3C, 8'hBD, 0);

        $display("[TB] bad checksum after reset");
        doReset();
        applyStimulus(8'h81, 8'h3C, 8'hBC, 0);

        $display("[TB] leading garbage before sync");
        sendBit(1'b1); sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
        applyStimulus(8'h12, 8'h34, 8'h26, 0);

        $display("[TB] stalled frame");
        applyStimulus(8'h81, 8'h3C, 8'hBD, 5);

        $display("[TB] clear mid-load");
        partial = {SYNC, 8'hFF};
        for (int i = 0; i < 13; i++) sendBit(partial[15-i]);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        bus.cfg_clear = 1'b1;
        @(negedge clk);
        bus.cfg_clear = 1'b0;
        model_sram = '0;
        checkOutput("clear_sram", {16'd0, bus.sram_con_bit}, 32'd0);
        checkOutput("clear_busy", {31'd0, bus.cfg_busy}, 32'd0);
        applyStimulus(8'h55, 8'hAA, 8'hFF, 0);

        $display("[TB] async reset mid-check");
        partial = {SYNC, 8'h0F};
        for (int i = 0; i < 16; i++) sendBit(partial[15-i]);
        for (int i = 0; i < 8; i++) sendBit(1'b1);
        for (int i = 0; i < 3; i++) sendBit(1'b0);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_sram",  {16'd0, bus.sram_con_bit}, 32'd0);
        checkOutput("arst_busy",  {31'd0, bus.cfg_busy},  32'd0);
        checkOutput("arst_done",  {31'd0, bus.cfg_done},  32'd0);
        checkOutput("arst_error", {31'd0, bus.cfg_error}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_sram = '0;
        applyStimulus(8'h0F, 8'hF0, 8'hFF, 0);

        $display("[TB] random frames");
        for (int n = 0; n < 4; n++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            c = (n % 2 == 0) ? (a ^ b) : (a ^ b ^ 8'h01);
            applyStimulus(a, b, c, 0);
        end

        repeat (5) @(negedge clk);
        checkOutput("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_config_loader.md
Name: iob_config_loader

Overview:
- Loads the 8-bit switch-enable words that drive the sram_con_bit inputs of an array of IOB pass-transistor switch blocks.
- Accepts a serial configuration bitstream in the form: sync byte, NUM_IOB data words, then an XOR checksum.
- Commits all words to the IOBs atomically, and only when the checksum matches.

Parameters:
- NUM_IOB, 4, number of IOBs configured; one WORD_W-bit word per IOB.
- WORD_W, 8, config word width; equals the IOB switch count.
- SYNC_WORD, 8'hA5, frame start pattern.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_din  input  1  serial config data, MSB-first.
- cfg_valid  input  1  cfg_din is sampled on each clk edge where this is high; when low, the block stalls.
- cfg_clear  input  1  synchronous request: zero all committed config and abort any frame in progress.
- sram_con_bit  output  NUM_IOB*WORD_W  committed config; IOB k uses bits [k*WORD_W +: WORD_W].
- cfg_busy  output  1  high in LOAD and CHECK states.
- cfg_done  output  1  one-cycle pulse: frame committed.
- cfg_error  output  1  one-cycle pulse: checksum mismatch; frame discarded.

Behaviour:
- Reset values:
  - sram_con_bit = 0 (all switches open).
  - cfg_busy = 0, cfg_done = 0, cfg_error = 0.
  - state = HUNT, all internal counters and registers zero.
- State HUNT:
  - Each accepted bit shifts into an 8-bit hunt register: hunt = {hunt[6:0], cfg_din}.
  - When the shifted value equals SYNC_WORD, go to LOAD on that same edge.
  - Overlapping matches are allowed.
  - The hunt register is cleared on every entry to HUNT.
- State LOAD:
  - Shift accepted bits into a NUM_IOB*WORD_W shadow register.
  - The first word received maps to IOB 0; each word is MSB-first.
  - A bit counter of width clog2(NUM_IOB*WORD_W) runs from 0 upward.
  - After the last data bit is accepted, go to CHECK.
  - A running XOR accumulator is updated per completed word.
- State CHECK:
  - Shift in WORD_W checksum bits.
  - On the edge that accepts the last checksum bit, compare against the XOR of all NUM_IOB shadow words.
  - Match: go to COMMIT. Mismatch: go to FAIL.
- State COMMIT (1 cycle):
  - sram_con_bit <= shadow.
  - cfg_done = 1 in this same cycle, so the new config and done become visible together.
  - Next state: HUNT.
- State FAIL (1 cycle):
  - cfg_error = 1.
  - sram_con_bit is unchanged.
  - Next state: HUNT.
- Latency: new config appears one clk after the final checksum bit is accepted.
- cfg_valid low in any state: no shift, no count, state held. COMMIT and FAIL ignore cfg_valid.
- cfg_clear:
  - Highest priority below rst.
  - Next cycle: sram_con_bit = 0, state = HUNT, shadow/counters/accumulator cleared.
  - No done or error pulse.
  - If asserted during COMMIT, the clear wins.
- rst mid-frame: the partial frame is lost and outputs return to reset values immediately.
- cfg_done and cfg_error are never high together.
- A sync pattern appearing inside data or checksum bits is ordinary data; it is not re-detected.

Decomposition:
- Shared package holds:
  - state enum: HUNT, LOAD, CHECK, COMMIT, FAIL.
  - SYNC_WORD default.
  - WORD_W default, matching the IOB switch count.
- One natural sub-module: iob_cfg_sync_hunt, holding the 8-bit hunt shift register and comparator, with a match pulse output.
- The shadow register, counters and FSM stay in the top level.

Test Plan:
- NUM_IOB=2, stream A5, 81, 3C, checksum BD, cfg_valid always high.
  - sram_con_bit = 16'h3C81.
  - cfg_done pulses once, one clk after the last bit.
  - cfg_busy is high for exactly 24 cycles.
- Same frame with checksum BC.
  - cfg_error pulses once; sram_con_bit keeps its prior value (0 after reset); cfg_done stays 0.
- Leading garbage 1101 before A5, then a valid frame.
  - Commits correctly, which proves sliding sync detection.
- Valid frame with cfg_valid deasserted for 3 cycles every 5th bit.
  - Same result as the first test; done arrives late by the total stall count.
- cfg_clear pulsed mid-LOAD after a previously committed 16'h3C81.
  - sram_con_bit = 0 next cycle; state is HUNT; a following valid frame commits normally.
- rst asserted asynchronously mid-CHECK.
  - All outputs are 0 immediately, without waiting for a clock edge; the next full frame commits correctly.
